// File: rtl/way_mru_tracker.sv
// Per-set valid/MRU keeper for a 4-way cache victim selector, with write-first lookup and a set-by-set flush.
// Optional hit/fill statistics counters are enabled by defining TRACKER_STATS_EN.
//
// state       | meaning
// ------------+----------------------------------------------------
// S_IDLE      | normal operation: updates, invalidates, lookups
// S_FLUSH     | clearing one set per cycle, lookups/updates blocked

module way_mru_tracker #(
    parameter int NUM_SETS = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         upd_valid,
    input  logic                                         upd_fill,
    input  logic [((NUM_SETS > 1) ? $clog2(NUM_SETS) : 1)-1:0] upd_set,
    input  logic [1:0]                                   upd_way,
    input  logic                                         inv_valid,
    input  logic [((NUM_SETS > 1) ? $clog2(NUM_SETS) : 1)-1:0] inv_set,
    input  logic [1:0]                                   inv_way,
    input  logic                                         rd_valid,
    input  logic [((NUM_SETS > 1) ? $clog2(NUM_SETS) : 1)-1:0] rd_set,
    output logic                                         rd_ready,
    output logic                                         rd_ack,
    output logic [3:0]                                   B,
    output logic [3:0]                                   D,
    output logic                                         hit_err,
    input  logic                                         flush_req,
    output logic                                         busy,
`ifdef TRACKER_STATS_EN
    output logic [15:0]                                  hit_cnt,
    output logic [15:0]                                  fill_cnt,
`endif
    output logic                                         flush_done
);

    localparam int SET_W = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]       state;
    logic [SET_W-1:0] flush_left;
    logic [SET_W-1:0] flush_set;

    logic [3:0] valid_mem [NUM_SETS];
    logic [3:0] mru_mem   [NUM_SETS];
    logic [3:0] nxt_valid [NUM_SETS];
    logic [3:0] nxt_mru   [NUM_SETS];

    logic       idle;
    logic       upd_in_range;
    logic       inv_in_range;
    logic       rd_in_range;
    logic       rd_accept;
    logic       hit_bad;
    logic [3:0] upd_oh;
    logic [3:0] inv_oh;

    assign busy         = (state == S_FLUSH);
    assign idle         = ~busy;
    assign rd_ready     = ~busy;
    assign rd_accept    = rd_valid & rd_ready;
    assign upd_in_range = (int'(upd_set) < NUM_SETS);
    assign inv_in_range = (int'(inv_set) < NUM_SETS);
    assign rd_in_range  = (int'(rd_set) < NUM_SETS);
    assign upd_oh       = 4'b0001 << upd_way;
    assign inv_oh       = 4'b0001 << inv_way;
    assign hit_bad      = idle & upd_valid & upd_in_range & ~upd_fill & ~valid_mem[upd_set][upd_way];
    // Flush walks sets upward while the terminal count runs down to zero.
    assign flush_set    = SET_W'(NUM_SETS - 1) - flush_left;

    // Post-update view of every set; storage writes and forwarded lookups share it.
    always_comb begin
        for (int s = 0; s < NUM_SETS; s++) begin
            nxt_valid[s] = valid_mem[s];
            nxt_mru[s]   = mru_mem[s];
            if (idle && upd_valid && upd_in_range && upd_set == SET_W'(s)) begin
                if (upd_fill) begin
                    nxt_valid[s][upd_way] = 1'b1;
                    nxt_mru[s]            = upd_oh;
                end else if (valid_mem[s][upd_way]) begin
                    nxt_mru[s] = upd_oh;
                end
            end
            // Applied after the update so a same-way invalidate wins.
            if (idle && inv_valid && inv_in_range && inv_set == SET_W'(s)) begin
                nxt_valid[s][inv_way] = 1'b0;
                if (nxt_mru[s] == inv_oh) begin
                    nxt_mru[s] = 4'b0000;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            flush_left <= '0;
            rd_ack     <= 1'b0;
            B          <= 4'b0000;
            D          <= 4'b0000;
            hit_err    <= 1'b0;
            flush_done <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_mem[s] <= 4'b0000;
                mru_mem[s]   <= 4'b0000;
            end
        end else begin
            rd_ack     <= rd_accept;
            hit_err    <= hit_bad;
            flush_done <= 1'b0;
            if (rd_accept) begin
                B <= rd_in_range ? nxt_valid[rd_set] : 4'b0000;
                D <= rd_in_range ? nxt_mru[rd_set]   : 4'b0000;
            end
            for (int s = 0; s < NUM_SETS; s++) begin
                if (idle) begin
                    valid_mem[s] <= nxt_valid[s];
                    mru_mem[s]   <= nxt_mru[s];
                end else if (flush_set == SET_W'(s)) begin
                    valid_mem[s] <= 4'b0000;
                    mru_mem[s]   <= 4'b0000;
                end
            end
            if (state == S_IDLE) begin
                if (flush_req) begin
                    state      <= S_FLUSH;
                    flush_left <= SET_W'(NUM_SETS - 1);
                end
            end else begin
                if (flush_left == '0) begin
                    state      <= S_IDLE;
                    flush_done <= 1'b1;
                end else begin
                    flush_left <= flush_left - 1'b1;
                end
            end
        end
    end

`ifdef TRACKER_STATS_EN
    logic hit_ok;
    logic fill_ok;

    assign hit_ok  = idle & upd_valid & upd_in_range & ~upd_fill & valid_mem[upd_set][upd_way];
    assign fill_ok = idle & upd_valid & upd_in_range & upd_fill;

    always_ff @(posedge clk) begin
        if (rst || (idle && flush_req)) begin
            hit_cnt  <= 16'h0000;
            fill_cnt <= 16'h0000;
        end else begin
            if (hit_ok && hit_cnt != 16'hFFFF) begin
                hit_cnt <= hit_cnt + 16'h0001;
            end
            if (fill_ok && fill_cnt != 16'hFFFF) begin
                fill_cnt <= fill_cnt + 16'h0001;
            end
        end
    end
`endif

endmodule
